user_btn_reset_conditioner: RTL and testbench
=============================================

// Module: user_btn_reset_conditioner
// PURPOSE
//  Turns the raw USER_BTN push-button into the clean active-low system reset that drives the Nios V
//  Platform Designer system's reset_reset_n input. Conditioning steps, in order:
//   - synchronise the button to clk_clk
//   - debounce it
//   - stretch the reset for a fixed hold time
//   - release the reset synchronously to clk_clk
//  Sits between the board pins (CLK_25M_C, USER_BTN) and the Nios V system.
// PARAMETERS
//  SYNC_STAGES        2        flops in the btn_n synchroniser chain (>=2)
//  DEBOUNCE_CYCLES    500000   consecutive stable cycles before a btn change is accepted (20 ms @ 25 MHz)
//  HOLD_CYCLES        256      cycles sys_reset_n stays low after a reset source is removed (>=1)
//  LONG_PRESS_CYCLES  75000000 press duration that flags a long press (3 s @ 25 MHz; LONG_PRESS_EN only)
// PORTS
//  clk_clk        in   1  25 MHz system clock (CLK_25M_C)
//  reset_reset_n  in   1  asynchronous, active-low block reset (power-on / PLL-locked)
//  btn_n          in   1  raw USER_BTN, active-low, asynchronous, bouncy
//  sys_reset_n    out  1  conditioned active-low reset to the Nios V system; registered
//  btn_db_n       out  1  debounced, synchronised button level (1 = released)
//  long_press     out  1  single-cycle pulse on a long press; tied 0 without LONG_PRESS_EN
// BEHAVIOUR
//  Block reset (reset_reset_n = 0)
//   - Async clear of all state.
//   - Sync chain = 1, btn_db_n = 1, sys_reset_n = 0, long_press = 0, FSM = S_HOLD, counters = 0.
//  Synchroniser
//   - btn_n passes through SYNC_STAGES flops to give btn_s.
//  Debouncer
//   - Counter clears whenever btn_s == btn_db_n.
//   - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, btn_db_n takes btn_s
//     on that edge and the counter clears.
//   - Any bounce shorter than DEBOUNCE_CYCLES is fully rejected.
//   - Counter width is $clog2(DEBOUNCE_CYCLES+1). It never wraps, because it saturates at the
//     update point.
//  FSM: sys_reset_n is registered and is 1 only in S_RUN.
//   - S_HOLD: hold counter increments each cycle.
//      * Counter at HOLD_CYCLES-1 and btn_db_n = 1 -> S_RUN, sys_reset_n = 1 on that edge.
//      * btn_db_n = 0 at any time -> S_ASSERT.
//   - S_RUN: btn_db_n = 0 -> S_ASSERT, sys_reset_n = 0 on the same edge.
//   - S_ASSERT: stays here while btn_db_n = 0.
//      * btn_db_n = 1 -> S_HOLD with the hold counter cleared, so the full hold restarts.
//  Timing
//   - After block reset: first edge with reset_reset_n = 1 is edge 1, so sys_reset_n rises on
//     edge HOLD_CYCLES (btn released).
//   - Press or release latency from btn_n to btn_db_n: SYNC_STAGES + DEBOUNCE_CYCLES edges.
//   - Press to sys_reset_n = 0: one further edge.
//  Reset mid-operation
//   - reset_reset_n asserted in any state forces sys_reset_n = 0 asynchronously.
//   - Deassertion always re-enters S_HOLD with a full hold.
//  Deassertion of sys_reset_n is always synchronous to clk_clk. Assertion is synchronous except
//  through reset_reset_n.
// CONFIGURATION
//  LONG_PRESS_EN defined
//   - Press counter runs in S_ASSERT and saturates.
//   - long_press pulses high for exactly one cycle when the counter reaches LONG_PRESS_CYCLES-1.
//   - At most one pulse per press; the counter clears on leaving S_ASSERT.
//  LONG_PRESS_EN undefined
//   - Press counter is not built and long_press is constant 0.
//   - All other behaviour is identical.
// TESTING (bench parameters: SYNC_STAGES=2, DEBOUNCE_CYCLES=8, HOLD_CYCLES=16, LONG_PRESS_CYCLES=40)
//  1. Release reset_reset_n with btn_n = 1
//     -> sys_reset_n = 0 through edge 15, = 1 from edge 16; btn_db_n stays 1.
//  2. In S_RUN, hold btn_n = 0 steady
//     -> btn_db_n = 0 after 10 edges; sys_reset_n = 0 one edge later; stays 0 while pressed.
//  3. In S_RUN, send btn_n glitches of 1, 3 and 7 cycles low, each separated by 2 cycles high
//     -> btn_db_n and sys_reset_n never change.
//  4. Press for 30 cycles, then release
//     -> btn_db_n returns to 1 after 10 edges; sys_reset_n = 1 exactly 16 edges after that.
//  5. Assert reset_reset_n mid-hold (counter = 9), then release
//     -> sys_reset_n = 0 immediately, then = 1 a full 16 edges after release.
//  6. LONG_PRESS_EN: press for 100 cycles
//     -> exactly one long_press pulse, 40 edges after the S_ASSERT entry. Without the macro,
//        long_press = 0 throughout.

Source files
------------

// File: rtl/user_btn_reset_conditioner.sv
// user_btn_reset_conditioner
//   Conditions the raw, bouncy, active-low USER_BTN into the clean active-low
//   system reset for the Nios V system. The button is synchronised to clk_clk,
//   debounced, and the reset is stretched for HOLD_CYCLES after every reset
//   source goes away. sys_reset_n is released only on a clock edge.
//   Optional feature macro: LONG_PRESS_EN adds a press-duration counter and a
//   single-cycle long_press pulse; without it long_press is tied low.
module user_btn_reset_conditioner #(
    parameter int SYNC_STAGES       = 2,
    parameter int DEBOUNCE_CYCLES   = 500000,
    parameter int HOLD_CYCLES       = 256,
    parameter int LONG_PRESS_CYCLES = 75000000
) (
    input  logic clk_clk,
    input  logic reset_reset_n,
    input  logic btn_n,
    output logic sys_reset_n,
    output logic btn_db_n,
    output logic long_press
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_HOLD   = 2'd0,
        S_RUN    = 2'd1,
        S_ASSERT = 2'd2
    } state_t;

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1 ||
        LONG_PRESS_CYCLES < 1) begin : g_param_check
        $error("user_btn_reset_conditioner: illegal parameter value");
    end

    logic [SYNC_STAGES-1:0] sync_p;
    logic                   btn_s;
    logic [DB_W-1:0]        db_cnt;
    logic [HOLD_W-1:0]      hold_cnt;
    state_t                 state;
    state_t                 state_next;

    // Synchroniser chain; resets to the released level so no false press is seen.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sync_p <= '1;
        end else begin
            sync_p <= {sync_p[SYNC_STAGES-2:0], btn_n};
        end
    end

    assign btn_s = sync_p[SYNC_STAGES-1];

    // Debouncer: accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            db_cnt   <= '0;
            btn_db_n <= 1'b1;
        end else if (btn_s == btn_db_n) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            btn_db_n <= btn_s;
            db_cnt   <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    // Reset FSM state register.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state <= S_HOLD;
        end else begin
            state <= state_next;
        end
    end

    // Reset FSM next-state logic; a pressed button always wins over the hold timer.
    always_comb begin
        state_next = state;
        case (state)
            S_HOLD: begin
                if (!btn_db_n) begin
                    state_next = S_ASSERT;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (!btn_db_n) begin
                    state_next = S_ASSERT;
                end
            end
            S_ASSERT: begin
                // A one-cycle hold is fully covered by the exit edge itself.
                if (btn_db_n) begin
                    state_next = (HOLD_CYCLES <= 1) ? S_RUN : S_HOLD;
                end
            end
            default: begin
                state_next = S_HOLD;
            end
        endcase
    end

    // Hold timer and registered reset output. The counter sits at zero outside
    // S_HOLD and counts every edge that lands in S_HOLD, including the edge that
    // leaves S_ASSERT, so the hold after a release lasts exactly HOLD_CYCLES edges
    // just like the hold after block reset.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            hold_cnt    <= '0;
            sys_reset_n <= 1'b0;
        end else begin
            hold_cnt    <= (state_next == S_HOLD) ? hold_cnt + 1'b1 : '0;
            sys_reset_n <= (state_next == S_RUN);
        end
    end

`ifdef LONG_PRESS_EN
    localparam int LP_W = $clog2(LONG_PRESS_CYCLES + 1);

    localparam logic [LP_W-1:0] LP_LAST = LP_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [LP_W-1:0] LP_SAT  = LP_W'(LONG_PRESS_CYCLES);

    logic [LP_W-1:0] press_cnt;

    // Press-duration counter; saturating one past the trigger point gives one pulse per press.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            press_cnt  <= '0;
            long_press <= 1'b0;
        end else begin
            long_press <= (state == S_ASSERT) && (press_cnt == LP_LAST);
            if (state != S_ASSERT) begin
                press_cnt <= '0;
            end else if (press_cnt != LP_SAT) begin
                press_cnt <= press_cnt + 1'b1;
            end
        end
    end
`else
    assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_user_btn_reset_conditioner.sv
// Testbench for user_btn_reset_conditioner (SYNC=2, DEBOUNCE=8, HOLD=16, LONG=40).
// A window-based reference model checks every edge; a vector table and a few
// hand-written sequences pin down the documented latencies.
module tb_user_btn_reset_conditioner;

    localparam int SYNC  = 2;
    localparam int DEB   = 8;
    localparam int HOLD  = 16;
    localparam int LONGP = 40;
    localparam int MAXE  = 16384;

    logic clk_clk       = 1'b0;
    logic reset_reset_n = 1'b1;
    logic btn_n         = 1'b1;
    logic sys_reset_n;
    logic btn_db_n;
    logic long_press;

    user_btn_reset_conditioner #(
        .SYNC_STAGES      (SYNC),
        .DEBOUNCE_CYCLES  (DEB),
        .HOLD_CYCLES      (HOLD),
        .LONG_PRESS_CYCLES(LONGP)
    ) dut (
        .clk_clk      (clk_clk),
        .reset_reset_n(reset_reset_n),
        .btn_n        (btn_n),
        .sys_reset_n  (sys_reset_n),
        .btn_db_n     (btn_db_n),
        .long_press   (long_press)
    );

    always #5 clk_clk = ~clk_clk;

    int errors = 0;
    int checks = 0;

    // Reference model: per-edge histories since the last block reset.
    logic bh  [0:MAXE];
    logic dbh [0:MAXE];
    int   lowrun [0:MAXE];
    int   k;
    int   last_rise;
    logic m_sys;
    logic m_db;
    logic m_long;

    typedef struct {
        logic btn;
        int   cycles;
        logic exp_db;
        logic exp_sys;
    } vec_t;

    vec_t vecs[$];

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Synchronised button as seen at edge j: the level driven SYNC edges earlier.
    function automatic logic bs(input int j);
        return (j - SYNC >= 1) ? bh[j - SYNC] : 1'b1;
    endfunction

    task automatic model_reset();
        k         = 0;
        last_rise = 0;
        bh[0]     = 1'b1;
        dbh[0]    = 1'b1;
        lowrun[0] = 0;
        m_sys     = 1'b0;
        m_db      = 1'b1;
        m_long    = 1'b0;
    endtask

    task automatic model_step(input logic b);
        logic prev;
        logic flip;
        if (k >= MAXE - 1) begin
            $display("FAIL model_overflow: got %0d edges, expected fewer than %0d", k, MAXE - 1);
            $fatal(1, "model history exhausted");
        end
        k++;
        bh[k] = b;
        prev  = dbh[k - 1];
        // The debounced level flips once the last DEB synchronised samples all disagree with it.
        flip = (k >= DEB);
        for (int j = k - DEB + 1; j <= k; j++) begin
            if (bs(j) == prev) flip = 1'b0;
        end
        dbh[k] = flip ? ~prev : prev;
        // Reset is released HOLD edges after the latest source removal, while still released.
        m_sys = dbh[k - 1] && ((k - last_rise) >= HOLD);
        if (dbh[k] && !dbh[k - 1]) last_rise = k;
        lowrun[k] = dbh[k] ? 0 : lowrun[k - 1] + 1;
`ifdef LONG_PRESS_EN
        m_long = (k >= 2) && (lowrun[k - 2] == LONGP);
`else
        m_long = 1'b0;
`endif
        m_db = dbh[k];
    endtask

    // One clock: drive between edges, advance the model, compare just after the edge.
    task automatic cyc(input logic b);
        btn_n = b;
        @(posedge clk_clk);
        model_step(b);
        #1;
        check_bit($sformatf("edge%0d_db", k), btn_db_n, m_db);
        check_bit($sformatf("edge%0d_sys", k), sys_reset_n, m_sys);
        check_bit($sformatf("edge%0d_long", k), long_press, m_long);
    endtask

    task automatic do_reset();
        reset_reset_n = 1'b0;
        btn_n         = 1'b1;
        #1;
        check_bit("rst_async_sys", sys_reset_n, 1'b0);
        check_bit("rst_db", btn_db_n, 1'b1);
        check_bit("rst_long", long_press, 1'b0);
        @(posedge clk_clk);
        #1;
        check_bit("rst_held_sys", sys_reset_n, 1'b0);
        reset_reset_n = 1'b1;
        model_reset();
    endtask

    task automatic wait_sys_high(input string name, input int exp_edge);
        int got;
        got = -1;
        for (int i = 1; i <= 40; i++) begin
            cyc(1'b1);
            if (got < 0 && sys_reset_n === 1'b1) got = i;
        end
        check_int(name, got, exp_edge);
    endtask

    task automatic add_vec(input logic b, input int n, input logic edb, input logic esys);
        vec_t v;
        v.btn     = b;
        v.cycles  = n;
        v.exp_db  = edb;
        v.exp_sys = esys;
        vecs.push_back(v);
    endtask

    initial begin
        int   pulses;
        int   pulse_at;
        logic b;
        int   len;

        // Power-up release, glitch rejection, 30-cycle press and release.
        add_vec(1'b1, 15, 1'b1, 1'b0);
        add_vec(1'b1,  1, 1'b1, 1'b1);
        add_vec(1'b1,  4, 1'b1, 1'b1);
        add_vec(1'b0,  1, 1'b1, 1'b1);
        add_vec(1'b1,  2, 1'b1, 1'b1);
        add_vec(1'b0,  3, 1'b1, 1'b1);
        add_vec(1'b1,  2, 1'b1, 1'b1);
        add_vec(1'b0,  7, 1'b1, 1'b1);
        add_vec(1'b1, 12, 1'b1, 1'b1);
        add_vec(1'b0,  9, 1'b1, 1'b1);
        add_vec(1'b0,  1, 1'b0, 1'b1);
        add_vec(1'b0,  1, 1'b0, 1'b0);
        add_vec(1'b0, 19, 1'b0, 1'b0);
        add_vec(1'b1,  9, 1'b0, 1'b0);
        add_vec(1'b1,  1, 1'b1, 1'b0);
        add_vec(1'b1, 15, 1'b1, 1'b0);
        add_vec(1'b1,  1, 1'b1, 1'b1);

        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            repeat (vecs[i].cycles) cyc(vecs[i].btn);
            check_bit($sformatf("vec%0d_db", i), btn_db_n, vecs[i].exp_db);
            check_bit($sformatf("vec%0d_sys", i), sys_reset_n, vecs[i].exp_sys);
        end

        // Block reset while running, then a full hold after release.
        do_reset();
        wait_sys_high("run_reset_release_edge", 16);

        // Block reset in the middle of a hold (counter at 9) restarts the full hold.
        do_reset();
        repeat (9) cyc(1'b1);
        do_reset();
        wait_sys_high("midhold_release_edge", 16);

        // 100-cycle press: long_press behaviour depends on the build.
        pulses   = 0;
        pulse_at = -1;
        for (int i = 1; i <= 100; i++) begin
            cyc(1'b0);
            if (long_press === 1'b1) begin
                pulses++;
                if (pulse_at < 0) pulse_at = i;
            end
        end
`ifdef LONG_PRESS_EN
        check_int("long_press_count", pulses, 1);
        check_int("long_press_edge", pulse_at, 51);
`else
        check_int("long_press_count", pulses, 0);
`endif
        repeat (30) cyc(1'b1);
        check_bit("long_release_sys", sys_reset_n, 1'b1);

        // Randomised button activity against the reference model.
        do_reset();
        for (int s = 0; s < 120; s++) begin
            b   = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 60))
                                              : int'($urandom_range(1, 12));
            repeat (len) cyc(b);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "timeout");
    end

endmodule
